ctl_diag_seq: RTL and testbench

- Diagnostic-function sequencer directly upstream of the CTL board interface.
- Accepts front-end diagnostic function codes and strobes, and produces the timed CTL diagnostic controls: DIAG_*_FUNC_* strobes, DIAG_CLK_EDP, DIAG_AR_LOAD, DIAG_LD_EBUS_REG, DIAG_READ, and the EBUS enables/transfer pulse.
- Converts a level-style front-end handshake into single-cycle or fixed-length pulses with a busy/done handshake back to the front end.

---
 rtl/ctl_diag_pkg.sv | 49 ++++
 rtl/ctl_diag_decode.sv | 31 +++
 rtl/ctl_diag_seq.sv | 200 ++++++++++++++++++++
 tb/tb_ctl_diag_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctl_diag_pkg.sv
// ctl_diag_pkg: shared states, octal function-code constants and decode struct for the CTL diagnostic sequencer
package ctl_diag_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DONE,
        WAIT_REL
    } state_t;

    // Group constants compare against the upper octal digits, code[6:3]
    localparam logic [3:0] FN_CTL_00 = 4'd0;
    localparam logic [3:0] FN_LD_04  = 4'd4;
    localparam logic [3:0] FN_LD_06  = 4'd6;
    localparam logic [3:0] FN_LD_07  = 4'd7;
    localparam logic [3:0] FN_RD_11  = 4'd9;
    localparam logic [3:0] FN_RD_12  = 4'd10;
    localparam logic [3:0] FN_RD_13  = 4'd11;
    localparam logic [3:0] FN_RD_14  = 4'd12;

    // Specific codes compare against the full 7-bit code
    localparam logic [6:0] FN_EBUS_070 = 7'o070;
    localparam logic [6:0] FN_LD_072   = 7'o072;
    localparam logic [6:0] FN_LD_073   = 7'o073;
    localparam logic [6:0] FN_LD_074   = 7'o074;
    localparam logic [6:0] FN_SYNC_075 = 7'o075;
    localparam logic [6:0] FN_LD_076   = 7'o076;
    localparam logic [6:0] FN_AR_077   = 7'o077;

    typedef struct packed {
        logic ctl00;
        logic ld04;
        logic ld06;
        logic ld07;
        logic ebus070;
        logic f072;
        logic f073;
        logic f074;
        logic s075;
        logic f076;
        logic ar077;
        logic rd11;
        logic rd12;
        logic rd13;
        logic rd14;
    } dec_t;

endpackage

// File: rtl/ctl_diag_decode.sv
// ctl_diag_decode: maps a 7-bit diagnostic function code to its strobe groups and a decoded flag
module ctl_diag_decode
    import ctl_diag_pkg::*;
(
    input  logic [6:0] func,
    output dec_t       dec,
    output logic       valid
);

    // Pure decode; every select is one-hot within its group and a code is valid if any select fires
    always_comb begin
        dec         = '0;
        dec.ctl00   = func[6:3] == FN_CTL_00;
        dec.ld04    = func[6:3] == FN_LD_04;
        dec.ld06    = func[6:3] == FN_LD_06;
        dec.ld07    = func[6:3] == FN_LD_07;
        dec.ebus070 = func == FN_EBUS_070;
        dec.f072    = func == FN_LD_072;
        dec.f073    = func == FN_LD_073;
        dec.f074    = func == FN_LD_074;
        dec.s075    = func == FN_SYNC_075;
        dec.f076    = func == FN_LD_076;
        dec.ar077   = func == FN_AR_077;
        dec.rd11    = func[6:3] == FN_RD_11;
        dec.rd12    = func[6:3] == FN_RD_12;
        dec.rd13    = func[6:3] == FN_RD_13;
        dec.rd14    = func[6:3] == FN_RD_14;
        valid       = |dec;
    end

endmodule

// File: rtl/ctl_diag_seq.sv
// ctl_diag_seq: turns the front-end strobe/function handshake into timed, registered CTL diagnostic controls
module ctl_diag_seq
    import ctl_diag_pkg::*;
#(
    parameter int READ_HOLD      = 4,
    parameter int EDP_CLK_CYCLES = 1
) (
    input  logic       clk,
    input  logic       CROBAR,
    input  logic [6:0] DIAG_FUNC,
    input  logic       DIAG_STROBE_IN,
    output logic       DIAG_CTL_FUNC_00x,
    output logic       DIAG_LD_FUNC_04x,
    output logic       DIAG_LOAD_FUNC_06x,
    output logic       DIAG_LOAD_FUNC_07x,
    output logic       DIAG_LOAD_FUNC_072,
    output logic       DIAG_LD_FUNC_073,
    output logic       DIAG_LD_FUNC_074,
    output logic       DIAG_SYNC_FUNC_075,
    output logic       DIAG_LD_FUNC_076,
    output logic       DIAG_READ_FUNC_11x,
    output logic       DIAG_READ_FUNC_12x,
    output logic       DIAG_READ_FUNC_13x,
    output logic       DIAG_READ_FUNC_14x,
    output logic       DIAG_CLK_EDP,
    output logic       DIAG_AR_LOAD,
    output logic       DIAG_LD_EBUS_REG,
    output logic       DIAG_STROBE,
    output logic       DIAG_READ,
    output logic       EBUS_T_TO_E_EN,
    output logic       EBUS_E_TO_T_EN,
    output logic       EBUS_XFER,
    output logic       DIAG_BUSY,
    output logic       DIAG_DONE,
    output logic       DIAG_BAD_FUNC,
    output logic       DIAG_OVERRUN
);

    state_t     state_q, state_d;
    logic [6:0] func_q, func_d;
    logic [3:0] cnt_q, cnt_d;
    dec_t       sel_q, sel_d;
    logic       hist_q, hist_d;
    logic       edp_q, edp_d;
    logic       stb_q, stb_d;
    logic       rd_q, rd_d;
    logic       t2e_q, t2e_d;
    logic       e2t_q, e2t_d;
    logic       xfer_q, xfer_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       bad_q, bad_d;
    logic       ovr_q, ovr_d;
    logic [6:0] code;
    dec_t       dec;
    logic       valid;
    logic       rise;

    // Idle decodes the live code so the first strobe cycle can be registered at the accepting edge
    assign code = (state_q == IDLE) ? DIAG_FUNC : func_q;
    assign rise = DIAG_STROBE_IN & ~hist_q;

    ctl_diag_decode u_decode (
        .func  (code),
        .dec   (dec),
        .valid (valid)
    );

    // Next-state and next-output computation; outputs are the values for the state being entered
    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        cnt_d   = cnt_q;
        sel_d   = '0;
        hist_d  = DIAG_STROBE_IN;
        edp_d   = 1'b0;
        stb_d   = 1'b0;
        rd_d    = 1'b0;
        t2e_d   = 1'b0;
        e2t_d   = 1'b0;
        xfer_d  = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        bad_d   = bad_q;
        ovr_d   = ovr_q | (rise && state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (rise) begin
                    func_d = DIAG_FUNC;
                    busy_d = 1'b1;
                    bad_d  = ~valid;
                    sel_d  = dec;
                    if (DIAG_FUNC[6]) begin
                        state_d = READ;
                        cnt_d   = 4'(READ_HOLD - 1);
                        rd_d    = 1'b1;
                        t2e_d   = 1'b1;
                        xfer_d  = valid && READ_HOLD == 1;
                    end else begin
                        state_d = WRITE;
                        cnt_d   = dec.ld06 ? 4'(EDP_CLK_CYCLES - 1) : 4'd0;
                        edp_d   = dec.ld06;
                        stb_d   = valid;
                        e2t_d   = valid;
                    end
                end
            end
            WRITE: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    edp_d = 1'b1;
                    e2t_d = 1'b1;
                end
            end
            READ: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q - 4'd1;
                    sel_d  = dec;
                    rd_d   = 1'b1;
                    t2e_d  = 1'b1;
                    xfer_d = valid && cnt_q == 4'd1;
                end
            end
            default: begin
                state_d = DIAG_STROBE_IN ? WAIT_REL : IDLE;
                busy_d  = DIAG_STROBE_IN;
            end
        endcase
    end

    // State and output registers; reset aborts any operation and arms the strobe history high
    always_ff @(posedge clk) begin
        if (CROBAR) begin
            state_q <= IDLE;
            func_q  <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            hist_q  <= 1'b1;
            edp_q   <= 1'b0;
            stb_q   <= 1'b0;
            rd_q    <= 1'b0;
            t2e_q   <= 1'b0;
            e2t_q   <= 1'b0;
            xfer_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bad_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            hist_q  <= hist_d;
            edp_q   <= edp_d;
            stb_q   <= stb_d;
            rd_q    <= rd_d;
            t2e_q   <= t2e_d;
            e2t_q   <= e2t_d;
            xfer_q  <= xfer_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bad_q   <= bad_d;
            ovr_q   <= ovr_d;
        end
    end

    assign DIAG_CTL_FUNC_00x  = sel_q.ctl00;
    assign DIAG_LD_FUNC_04x   = sel_q.ld04;
    assign DIAG_LOAD_FUNC_06x = sel_q.ld06;
    assign DIAG_LOAD_FUNC_07x = sel_q.ld07;
    assign DIAG_LD_EBUS_REG   = sel_q.ebus070;
    assign DIAG_LOAD_FUNC_072 = sel_q.f072;
    assign DIAG_LD_FUNC_073   = sel_q.f073;
    assign DIAG_LD_FUNC_074   = sel_q.f074;
    assign DIAG_SYNC_FUNC_075 = sel_q.s075;
    assign DIAG_LD_FUNC_076   = sel_q.f076;
    assign DIAG_AR_LOAD       = sel_q.ar077;
    assign DIAG_READ_FUNC_11x = sel_q.rd11;
    assign DIAG_READ_FUNC_12x = sel_q.rd12;
    assign DIAG_READ_FUNC_13x = sel_q.rd13;
    assign DIAG_READ_FUNC_14x = sel_q.rd14;
    assign DIAG_CLK_EDP       = edp_q;
    assign DIAG_STROBE        = stb_q;
    assign DIAG_READ          = rd_q;
    assign EBUS_T_TO_E_EN     = t2e_q;
    assign EBUS_E_TO_T_EN     = e2t_q;
    assign EBUS_XFER          = xfer_q;
    assign DIAG_BUSY          = busy_q;
    assign DIAG_DONE          = done_q;
    assign DIAG_BAD_FUNC      = bad_q;
    assign DIAG_OVERRUN       = ovr_q;

endmodule

// File: tb/tb_ctl_diag_seq.sv
// tb_ctl_diag_seq: table vectors, corner sequences and randomized traffic against a cycle-trace reference model
module tb_ctl_diag_seq;

    localparam int RH  = 4;
    localparam int EDP = 3;

    localparam logic [24:0] B_CTL  = 25'd1 << 0;
    localparam logic [24:0] B_LD04 = 25'd1 << 1;
    localparam logic [24:0] B_LD06 = 25'd1 << 2;
    localparam logic [24:0] B_LD07 = 25'd1 << 3;
    localparam logic [24:0] B_F072 = 25'd1 << 4;
    localparam logic [24:0] B_F073 = 25'd1 << 5;
    localparam logic [24:0] B_F074 = 25'd1 << 6;
    localparam logic [24:0] B_S075 = 25'd1 << 7;
    localparam logic [24:0] B_F076 = 25'd1 << 8;
    localparam logic [24:0] B_RD11 = 25'd1 << 9;
    localparam logic [24:0] B_RD12 = 25'd1 << 10;
    localparam logic [24:0] B_RD13 = 25'd1 << 11;
    localparam logic [24:0] B_RD14 = 25'd1 << 12;
    localparam logic [24:0] B_EDP  = 25'd1 << 13;
    localparam logic [24:0] B_AR   = 25'd1 << 14;
    localparam logic [24:0] B_EBUS = 25'd1 << 15;
    localparam logic [24:0] B_STB  = 25'd1 << 16;
    localparam logic [24:0] B_READ = 25'd1 << 17;
    localparam logic [24:0] B_T2E  = 25'd1 << 18;
    localparam logic [24:0] B_E2T  = 25'd1 << 19;
    localparam logic [24:0] B_BUSY = 25'd1 << 21;
    localparam logic [24:0] B_BAD  = 25'd1 << 23;
    localparam logic [24:0] W_BASE = B_STB | B_E2T | B_BUSY;
    localparam logic [24:0] R_BASE = B_READ | B_T2E | B_BUSY;

    logic       clk = 1'b0;
    logic       CROBAR;
    logic [6:0] DIAG_FUNC;
    logic       DIAG_STROBE_IN;
    logic       DIAG_CTL_FUNC_00x, DIAG_LD_FUNC_04x, DIAG_LOAD_FUNC_06x, DIAG_LOAD_FUNC_07x;
    logic       DIAG_LOAD_FUNC_072, DIAG_LD_FUNC_073, DIAG_LD_FUNC_074, DIAG_SYNC_FUNC_075, DIAG_LD_FUNC_076;
    logic       DIAG_READ_FUNC_11x, DIAG_READ_FUNC_12x, DIAG_READ_FUNC_13x, DIAG_READ_FUNC_14x;
    logic       DIAG_CLK_EDP, DIAG_AR_LOAD, DIAG_LD_EBUS_REG, DIAG_STROBE, DIAG_READ;
    logic       EBUS_T_TO_E_EN, EBUS_E_TO_T_EN, EBUS_XFER;
    logic       DIAG_BUSY, DIAG_DONE, DIAG_BAD_FUNC, DIAG_OVERRUN;
    logic [24:0] obs;

    always #5 clk = ~clk;

    ctl_diag_seq #(.READ_HOLD(RH), .EDP_CLK_CYCLES(EDP)) dut (
        .clk                (clk),
        .CROBAR             (CROBAR),
        .DIAG_FUNC          (DIAG_FUNC),
        .DIAG_STROBE_IN     (DIAG_STROBE_IN),
        .DIAG_CTL_FUNC_00x  (DIAG_CTL_FUNC_00x),
        .DIAG_LD_FUNC_04x   (DIAG_LD_FUNC_04x),
        .DIAG_LOAD_FUNC_06x (DIAG_LOAD_FUNC_06x),
        .DIAG_LOAD_FUNC_07x (DIAG_LOAD_FUNC_07x),
        .DIAG_LOAD_FUNC_072 (DIAG_LOAD_FUNC_072),
        .DIAG_LD_FUNC_073   (DIAG_LD_FUNC_073),
        .DIAG_LD_FUNC_074   (DIAG_LD_FUNC_074),
        .DIAG_SYNC_FUNC_075 (DIAG_SYNC_FUNC_075),
        .DIAG_LD_FUNC_076   (DIAG_LD_FUNC_076),
        .DIAG_READ_FUNC_11x (DIAG_READ_FUNC_11x),
        .DIAG_READ_FUNC_12x (DIAG_READ_FUNC_12x),
        .DIAG_READ_FUNC_13x (DIAG_READ_FUNC_13x),
        .DIAG_READ_FUNC_14x (DIAG_READ_FUNC_14x),
        .DIAG_CLK_EDP       (DIAG_CLK_EDP),
        .DIAG_AR_LOAD       (DIAG_AR_LOAD),
        .DIAG_LD_EBUS_REG   (DIAG_LD_EBUS_REG),
        .DIAG_STROBE        (DIAG_STROBE),
        .DIAG_READ          (DIAG_READ),
        .EBUS_T_TO_E_EN     (EBUS_T_TO_E_EN),
        .EBUS_E_TO_T_EN     (EBUS_E_TO_T_EN),
        .EBUS_XFER          (EBUS_XFER),
        .DIAG_BUSY          (DIAG_BUSY),
        .DIAG_DONE          (DIAG_DONE),
        .DIAG_BAD_FUNC      (DIAG_BAD_FUNC),
        .DIAG_OVERRUN       (DIAG_OVERRUN)
    );

    assign obs = {DIAG_OVERRUN, DIAG_BAD_FUNC, DIAG_DONE, DIAG_BUSY, EBUS_XFER, EBUS_E_TO_T_EN,
                  EBUS_T_TO_E_EN, DIAG_READ, DIAG_STROBE, DIAG_LD_EBUS_REG, DIAG_AR_LOAD, DIAG_CLK_EDP,
                  DIAG_READ_FUNC_14x, DIAG_READ_FUNC_13x, DIAG_READ_FUNC_12x, DIAG_READ_FUNC_11x,
                  DIAG_LD_FUNC_076, DIAG_SYNC_FUNC_075, DIAG_LD_FUNC_074, DIAG_LD_FUNC_073,
                  DIAG_LOAD_FUNC_072, DIAG_LOAD_FUNC_07x, DIAG_LOAD_FUNC_06x, DIAG_LD_FUNC_04x,
                  DIAG_CTL_FUNC_00x};

    int total  = 0;
    int passed = 0;

    // Reference model: t counts edges since the operation was accepted (0 = idle)
    int         m_t    = 0;
    logic [6:0] m_code = '0;
    logic       m_prev = 1'b1;
    logic       m_bad  = 1'b0;
    logic       m_ovr  = 1'b0;

    function automatic logic m_dec(logic [6:0] c);
        int g;
        g = int'(c[6:3]);
        return c[6] ? (g >= 9 && g <= 12) : (g == 0 || g == 4 || g == 6 || g == 7);
    endfunction

    function automatic int m_len(logic [6:0] c);
        return c[6] ? RH : (c[6:3] == 4'd6 ? EDP : 1);
    endfunction

    function automatic logic [24:0] m_exp();
        logic [24:0] v;
        int g, n;
        logic dd;
        v  = '0;
        g  = int'(m_code[6:3]);
        n  = m_len(m_code);
        dd = m_dec(m_code);
        v[21] = m_t > 0;
        if (m_t >= 1 && m_t <= n) begin
            if (m_code[6]) begin
                v[17] = 1'b1;
                v[18] = 1'b1;
                v[9]  = g == 9;
                v[10] = g == 10;
                v[11] = g == 11;
                v[12] = g == 12;
                v[20] = dd && m_t == n;
            end else begin
                v[0]  = g == 0;
                v[1]  = g == 4;
                v[2]  = g == 6 && m_t == 1;
                v[3]  = g == 7;
                v[4]  = m_code == 7'o072;
                v[5]  = m_code == 7'o073;
                v[6]  = m_code == 7'o074;
                v[7]  = m_code == 7'o075;
                v[8]  = m_code == 7'o076;
                v[13] = g == 6;
                v[14] = m_code == 7'o077;
                v[15] = m_code == 7'o070;
                v[16] = dd && m_t == 1;
                v[19] = dd;
            end
        end
        v[22] = m_t == n + 1;
        v[23] = m_bad;
        v[24] = m_ovr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic step(input logic s, input logic [6:0] f, input logic r);
        logic rise;
        DIAG_STROBE_IN = s;
        DIAG_FUNC      = f;
        CROBAR         = r;
        @(posedge clk);
        if (r) begin
            m_t    = 0;
            m_prev = 1'b1;
            m_bad  = 1'b0;
            m_ovr  = 1'b0;
        end else begin
            rise   = s && !m_prev;
            m_prev = s;
            if (m_t == 0) begin
                if (rise) begin
                    m_code = f;
                    m_t    = 1;
                    m_bad  = !m_dec(f);
                end
            end else begin
                if (rise) m_ovr = 1'b1;
                if (m_t >= m_len(m_code) + 1 && !s) m_t = 0;
                else m_t++;
            end
        end
        @(negedge clk);
        chk("trace", 32'(obs), 32'(m_exp()));
    endtask

    typedef struct {
        logic [6:0]  code;
        logic [24:0] first;
        int          done_at;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic        s;
        logic [6:0]  f;
        logic [7:0]  edp_pat, done_pat, busy_pat;
        int          n, dcount;
        logic        found;
        tbl[0]  = '{7'o003, B_CTL | W_BASE, 2};
        tbl[1]  = '{7'o045, B_LD04 | W_BASE, 2};
        tbl[2]  = '{7'o064, B_LD06 | B_EDP | W_BASE, 4};
        tbl[3]  = '{7'o070, B_LD07 | B_EBUS | W_BASE, 2};
        tbl[4]  = '{7'o071, B_LD07 | W_BASE, 2};
        tbl[5]  = '{7'o072, B_LD07 | B_F072 | W_BASE, 2};
        tbl[6]  = '{7'o073, B_LD07 | B_F073 | W_BASE, 2};
        tbl[7]  = '{7'o074, B_LD07 | B_F074 | W_BASE, 2};
        tbl[8]  = '{7'o075, B_LD07 | B_S075 | W_BASE, 2};
        tbl[9]  = '{7'o076, B_LD07 | B_F076 | W_BASE, 2};
        tbl[10] = '{7'o017, B_BUSY | B_BAD, 2};
        tbl[11] = '{7'o113, B_RD11 | R_BASE, 5};
        tbl[12] = '{7'o124, B_RD12 | R_BASE, 5};
        tbl[13] = '{7'o137, B_RD13 | R_BASE, 5};
        tbl[14] = '{7'o146, B_RD14 | R_BASE, 5};
        tbl[15] = '{7'o155, R_BASE | B_BAD, 5};
        tbl[16] = '{7'o077, B_LD07 | B_AR | W_BASE, 2};
        DIAG_STROBE_IN = 1'b0;
        DIAG_FUNC      = '0;
        CROBAR         = 1'b1;
        step(1'b0, 7'o000, 1'b1);
        step(1'b0, 7'o000, 1'b1);
        chk("reset_state", 32'(obs), 32'd0);
        step(1'b0, 7'o000, 1'b0);
        for (int i = 0; i < 17; i++) begin
            step(1'b1, tbl[i].code, 1'b0);
            chk("tbl_first", 32'(obs), 32'(tbl[i].first));
            n = 1;
            found = 1'b0;
            while (n < 12 && !found) begin
                step(1'b0, tbl[i].code, 1'b0);
                n++;
                found = obs[22];
            end
            chk("tbl_done_at", found ? n : 0, tbl[i].done_at);
            step(1'b0, tbl[i].code, 1'b0);
            chk("tbl_idle", 32'(obs[21]), 32'd0);
        end
        edp_pat = '0;
        done_pat = '0;
        busy_pat = '0;
        for (int j = 0; j < 8; j++) begin
            step(1'b1, 7'o064, 1'b0);
            edp_pat[j]  = obs[13];
            done_pat[j] = obs[22];
            busy_pat[j] = obs[21];
        end
        chk("edp_pattern", 32'(edp_pat), 32'h07);
        chk("edp_done_pattern", 32'(done_pat), 32'h08);
        chk("busy_hold", 32'(busy_pat), 32'hFF);
        step(1'b0, 7'o064, 1'b0);
        chk("busy_release", 32'(obs[21]), 32'd0);
        step(1'b1, 7'o124, 1'b0);
        step(1'b1, 7'o124, 1'b0);
        step(1'b0, 7'o124, 1'b0);
        step(1'b1, 7'o003, 1'b0);
        chk("overrun_set", 32'(obs[24]), 32'd1);
        dcount = 0;
        for (int j = 0; j < 6; j++) begin
            step(1'b0, 7'o003, 1'b0);
            dcount += int'(obs[22]);
        end
        chk("overrun_single_done", dcount, 1);
        chk("overrun_idle", 32'(obs[21]), 32'd0);
        step(1'b1, 7'o124, 1'b0);
        step(1'b1, 7'o124, 1'b0);
        step(1'b1, 7'o124, 1'b1);
        chk("reset_abort_zero", 32'(obs), 32'd0);
        for (int j = 0; j < 3; j++) begin
            step(1'b1, 7'o124, 1'b0);
            chk("no_retrigger", 32'({obs[21], obs[22]}), 32'd0);
        end
        step(1'b0, 7'o124, 1'b0);
        step(1'b1, 7'o124, 1'b0);
        chk("retrigger", 32'(obs[21] & obs[10]), 32'd1);
        for (int j = 0; j < 8; j++) step(1'b0, 7'o000, 1'b0);
        s = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) s = ~s;
            f = ($urandom_range(0, 3) == 0) ? 7'($urandom) : tbl[$urandom_range(0, 16)].code;
            step(s, f, $urandom_range(0, 199) == 0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
